// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared definitions for the register-file dump sequencer.
//   state_t    - FSM state encoding (also exported on the debug state port)
//   REG_IDX_W  - width of a register index / read-port number
//   REG_DATA_W - width of a register value
package reg_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int REG_IDX_W  = 5;
    localparam int REG_DATA_W = 32;

endpackage

// File: rtl/reg_dump.sv
// reg_dump: debug read-out sequencer. Walks one register-file read port from
// FIRST_REG to LAST_REG and streams each register as an {index, data} beat.
// While a dump is in flight it raises stall_req so the datapath holds its
// writes, which makes the streamed registers a coherent snapshot.
//
// Ports:
//   clk         in   clock, all state changes on posedge
//   reset       in   synchronous active-high reset
//   start       in   dump request, only looked at in IDLE
//   abort       in   end the dump at once, no done pulse
//   RN          out  read-register number driven to reg_file
//   RD          in   combinational read data from that port
//   stall_req   out  datapath must not write registers while high
//   busy        out  high whenever the FSM is not IDLE
//   done        out  one-cycle pulse after the last beat is accepted
//   out_valid   out  beat available
//   out_ready   in   consumer takes the beat
//   out_index   out  register number of the beat
//   out_data    out  register contents of the beat
//   o_dbg_state out  current FSM state
//
// Handshake: a beat transfers on a posedge where out_valid and out_ready are
// both high. Once out_valid is raised, out_valid, out_index and out_data stay
// unchanged until that transfer; only abort or reset may withdraw the beat.
import reg_dump_pkg::*;

module reg_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [REG_IDX_W-1:0]  RN,
    input  logic [REG_DATA_W-1:0] RD,
    output logic                  stall_req,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_IDX_W-1:0]  out_index,
    output logic [REG_DATA_W-1:0] out_data,
    output state_t                o_dbg_state
);

    localparam logic [REG_IDX_W-1:0] W_FIRST = REG_IDX_W'(FIRST_REG);
    localparam logic [REG_IDX_W-1:0] W_LAST  = REG_IDX_W'(LAST_REG);

    state_t                  r_state;
    logic [REG_IDX_W-1:0]    r_idx;
    logic [REG_IDX_W-1:0]    r_rn;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_out_valid;
    logic [REG_IDX_W-1:0]    r_out_index;
    logic [REG_DATA_W-1:0]   r_out_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_rn        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_data  <= '0;
        end else if (abort) begin
            // Abort beats any handshake on this edge: the beat is withdrawn
            // and counts as not delivered. In IDLE this also masks start.
            r_state     <= ST_IDLE;
            r_rn        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_idx   <= W_FIRST;
                        r_rn    <= W_FIRST;
                        r_busy  <= 1'b1;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    // RN has been stable for this whole cycle, so RD is settled.
                    r_out_data  <= RD;
                    r_out_index <= r_idx;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_idx == W_LAST) begin
                            r_rn    <= '0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            // LAST_REG <= 31, so this never wraps.
                            r_idx   <= r_idx + 1'b1;
                            r_rn    <= r_idx + 1'b1;
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign RN          = r_rn;
    assign busy        = r_busy;
    assign stall_req   = r_busy;
    assign done        = r_done;
    assign out_valid   = r_out_valid;
    assign out_index   = r_out_index;
    assign out_data    = r_out_data;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_reg_dump.sv
module tb_reg_dump;
  import reg_dump_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  rn;
  logic [31:0] rd;
  logic        stall_req, busy, done, out_valid;
  logic [4:0]  out_index;
  logic [31:0] out_data;
  state_t      dbg_state;

  // second instance: single-register window 5..5
  logic        start1 = 1'b0;
  logic        abort1 = 1'b0;
  logic        ready1 = 1'b1;
  logic [4:0]  rn1;
  logic [31:0] rd1;
  logic        stall1, busy1, done1, valid1;
  logic [4:0]  index1;
  logic [31:0] data1;
  state_t      dbg_state1;

  // register file model: r0 always reads as zero
  logic [31:0] regs [32];
  always_comb rd  = (rn  == 5'd0) ? 32'd0 : regs[rn];
  always_comb rd1 = (rn1 == 5'd0) ? 32'd0 : regs[rn1];

  reg_dump u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .RN(rn), .RD(rd), .stall_req(stall_req), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_data(out_data), .o_dbg_state(dbg_state)
  );

  reg_dump #(.FIRST_REG(5), .LAST_REG(5)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .RN(rn1), .RD(rd1), .stall_req(stall1), .busy(busy1), .done(done1),
    .out_valid(valid1), .out_ready(ready1), .out_index(index1),
    .out_data(data1), .o_dbg_state(dbg_state1)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  logic        prev_hold = 1'b0;
  logic        prev_kill = 1'b0;
  logic [36:0] prev_beat = '0;

  // Inputs change 1 time unit after posedge, so the negedge sees exactly
  // what the next posedge will act on.
  always @(negedge clk) begin
    logic [36:0] got;
    logic [36:0] exp;
    got = {out_index, out_data};
    if (prev_hold && !prev_kill) begin
      n_vec++;
      if (!out_valid) begin
        n_err++;
        $display("FAIL hold_valid: out_valid=%0b required 1 (dropped without handshake)", out_valid);
      end else if (got !== prev_beat) begin
        n_err++;
        $display("FAIL hold_stable: beat=%h required %h", got, prev_beat);
      end
    end
    if (out_valid && out_ready && !reset && !abort) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected: got index=%0d data=%h, none required", out_index, out_data);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_err++;
          $display("FAIL beat: got index=%0d data=%h required index=%0d data=%h",
                   out_index, out_data, exp[36:32], exp[31:0]);
        end
      end
    end
    prev_hold = out_valid && !out_ready;
    prev_kill = reset || abort;
    prev_beat = got;
  end

  // ---------------- driver tasks ----------------
  task automatic preload();
    for (int n = 0; n < 32; n++) regs[n] = 32'd100 + 32'(n);
  endtask

  task automatic push_beats(input int first, input int last);
    for (int n = first; n <= last; n++)
      exp_q.push_back({5'(n), (n == 0) ? 32'd0 : 32'd100 + 32'(n)});
  endtask

  // Leaves the bench 1 unit after edge E0 (the edge that samples start).
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Counts edges until done is seen; cyc = -1 if max_cyc runs out.
  task automatic run_until_done(input int max_cyc, input bit rand_ready,
                                input int start_at, output int cyc);
    cyc = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge clk); #1;
      start = (k == start_at);
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      if (done) begin
        cyc = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, stall_req, done, out_valid, rn, out_index, out_data, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%0b stall=%0b done=%0b valid=%0b RN=%0d idx=%0d data=%h state=%0d required all 0",
               busy, stall_req, done, out_valid, rn, out_index, out_data, dbg_state);
    end
    n_vec++;
    if ({busy1, stall1, done1, valid1, rn1, index1, data1} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs1: busy=%0b valid=%0b RN=%0d required 0", busy1, valid1, rn1);
    end
    reset = 1'b0;
  endtask

  task automatic test_full_dump();
    int cyc;
    preload();
    out_ready = 1'b1;
    push_beats(0, 31);
    pulse_start();
    n_vec++;
    if (busy !== 1'b1 || stall_req !== 1'b1 || out_valid !== 1'b0 || rn !== 5'd0) begin
      n_err++;
      $display("FAIL start_e0: busy=%0b stall=%0b valid=%0b RN=%0d required 1 1 0 0",
               busy, stall_req, out_valid, rn);
    end
    run_until_done(200, 1'b0, -1, cyc);
    n_vec++;
    if (cyc !== 64) begin
      n_err++;
      $display("FAIL full_done_cycle: done after edge %0d required 64", cyc);
    end
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || stall_req !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL full_after_done: busy=%0b stall=%0b done=%0b required 0 0 0", busy, stall_req, done);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL full_drained: %0d beats missing required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    preload();
    for (int n = 1; n < 32; n++) regs[n] = $urandom;
    for (int n = 0; n < 32; n++)
      exp_q.push_back({5'(n), (n == 0) ? 32'd0 : regs[n]});
    out_ready = 1'b0;
    pulse_start();
    run_until_done(2000, 1'b1, -1, cyc);
    n_vec++;
    if (cyc < 64) begin
      n_err++;
      $display("FAIL bp_done: done after edge %0d required >= 64", cyc);
    end
    @(posedge clk); #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_drained: %0d beats missing required 0", exp_q.size());
      exp_q.delete();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_single();
    int done_at = -1;
    int beats = 0;
    logic [36:0] beat = '0;
    regs[5] = 32'hDEADBEEF;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    n_vec++;
    if (rn1 !== 5'd5 || busy1 !== 1'b1) begin
      n_err++;
      $display("FAIL single_read_rn: RN=%0d busy=%0b required 5 1", rn1, busy1);
    end
    for (int k = 1; k <= 10; k++) begin
      if (valid1 && ready1) begin
        beats++;
        beat = {index1, data1};
      end
      if (done1 && done_at < 0) done_at = k - 1;
      @(posedge clk); #1;
    end
    n_vec++;
    if (beats !== 1 || beat !== {5'd5, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL single_beat: beats=%0d beat=%h required 1 %h", beats, beat, {5'd5, 32'hDEADBEEF});
    end
    n_vec++;
    if (done_at !== 2) begin
      n_err++;
      $display("FAIL single_done: done after edge %0d required 2", done_at);
    end
  endtask

  task automatic test_abort();
    int cyc;
    bit found = 1'b0;
    preload();
    out_ready = 1'b1;
    push_beats(0, 9);
    pulse_start();
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (out_valid && out_index == 5'd10) begin
        found = 1'b1;
        break;
      end
    end
    out_ready = 1'b0;
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL abort_reach: beat 10 not presented required presented");
    end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL abort_idle: valid=%0b busy=%0b done=%0b state=%0d required 0 0 0 0",
               out_valid, busy, done, dbg_state);
    end
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (done || busy) found = 1'b1;
    end
    n_vec++;
    if (found) begin
      n_err++;
      $display("FAIL abort_quiet: done/busy seen after abort required none");
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL abort_delivered: %0d beats missing required 0", exp_q.size());
      exp_q.delete();
    end
    // replay from index 0
    out_ready = 1'b1;
    push_beats(0, 31);
    pulse_start();
    run_until_done(200, 1'b0, -1, cyc);
    n_vec++;
    if (cyc !== 64 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL abort_replay: done after edge %0d, %0d beats missing, required 64 and 0", cyc, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit found = 1'b0;
    preload();
    out_ready = 1'b1;
    push_beats(0, 6);
    pulse_start();
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (out_valid && out_index == 5'd7) begin
        found = 1'b1;
        break;
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (!found || {busy, stall_req, done, out_valid, rn, out_index, out_data, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: found=%0b busy=%0b valid=%0b RN=%0d idx=%0d data=%h state=%0d required found and all 0",
               found, busy, out_valid, rn, out_index, out_data, dbg_state);
    end
    reset = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid_delivered: %0d beats missing required 0", exp_q.size());
      exp_q.delete();
    end
    // start pulses mid-dump and on the DONE cycle must not retrigger
    push_beats(0, 31);
    pulse_start();
    run_until_done(200, 1'b0, 20, cyc);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_vec++;
    if (cyc !== 64) begin
      n_err++;
      $display("FAIL restart_done: done after edge %0d required 64", cyc);
    end
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (busy || out_valid) found = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++;
    if (found || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL no_second_dump: activity=%0b missing=%0d required 0 0", found, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    preload();
    test_reset();
    test_full_dump();
    test_backpressure();
    test_single();
    test_abort();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
# reg_dump

Debug read-out sequencer that walks the register file's read ports and streams every register as an {index, data} beat over a valid/ready interface. It drives one read port of `reg_file` (RN1 or RN2, chosen at integration) and asserts a stall request so the datapath issues no writes while a dump is in flight, giving a coherent snapshot. It sits beside the register file, between the CPU datapath and the debug/trace channel.

## Interface
Parameters:
- FIRST_REG, 0: first register index dumped. Register 0 reads as 0 through `reg_file`.
- LAST_REG, 31: last register index dumped. Constraint: FIRST_REG <= LAST_REG <= 31.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high. Sampled on posedge clk.
- start  in  1  dump request; sampled only in IDLE.
- abort  in  1  terminates a dump without a done pulse.
- RN  out  5  read-register number to a `reg_file` read port.
- RD  in  32  combinational read data returned from that port.
- stall_req  out  1  high whenever state != IDLE; datapath must hold RegWrite low.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts the beat.
- out_index  out  5  register number of the current beat.
- out_data  out  32  register contents of the current beat.

## Operation
- States: IDLE, READ, SEND, DONE. A 5-bit counter `idx` holds the register index.
- IDLE:
  - RN=0, out_valid=0.
  - start=1 -> idx<=FIRST_REG, go to READ.
- READ:
  - RN=idx.
  - On the next edge, out_data<=RD, out_index<=idx, go to SEND.
- SEND:
  - out_valid=1. out_data and out_index are held stable until the beat is accepted.
  - out_valid=1 and out_ready=1 at an edge = beat accepted.
  - Accepted with idx==LAST_REG -> go to DONE.
  - Accepted otherwise -> idx<=idx+1, go to READ.
  - No beat accepted -> stay in SEND.
- DONE: done=1 for one cycle, then go to IDLE.
- Priority at each edge, highest first:
  1. reset
  2. abort
  3. normal transitions
- abort=1 in any non-IDLE state -> go to IDLE next cycle.
  - out_valid drops.
  - No done pulse.
  - A beat handshaking in the same cycle counts as not delivered.
- start is ignored outside IDLE. start and abort together in IDLE -> abort wins and the block stays in IDLE.
- idx never wraps: LAST_REG is at most 31, so idx+1 is never taken from 31.
- Width rules:
  - idx, RN and out_index are 5 bits.
  - out_data is RD registered unchanged, with no sign or width manipulation.

## Timing
- Reset values: state=IDLE, idx=0, RN=0, out_valid=0, out_index=0, out_data=0, busy=0, stall_req=0, done=0.
- Reset mid-dump returns the block to IDLE on the same edge with all outputs at their reset values.
- start high at edge E0:
  - busy and stall_req high after E0.
  - RN=FIRST_REG during cycle E0..E1.
  - First out_valid after E1.
- Minimum two cycles per beat (READ + SEND), because the read is registered before it is presented.
- Dump time with out_ready tied high:
  - 2*(LAST_REG-FIRST_REG+1) cycles, then 1 DONE cycle.
  - Defaults: 64 cycles, done high in cycle 65 after E0, busy low after that.
- out_valid never deasserts without a handshake, except on abort or reset.
- stall_req is a registered state decode. The datapath sees it in the cycle after start is accepted. The integrator must gate the RegWrite edge at E1 or later. A write at edge E0 itself lands before READ samples.

## Structure
- Shared package `reg_dump_pkg` holds:
  - the state encoding: IDLE=2'd0, READ=2'd1, SEND=2'd2, DONE=2'd3;
  - the constant REG_IDX_W=5;
  - the constant REG_DATA_W=32.
- A single flat module. The output holding register is simple enough that no sub-module is warranted.

## Test plan
- Preload r1..r31 with values 100+n, out_ready=1, pulse start -> 32 beats:
  - index 0..31 in order;
  - data 0, 101, ..., 131;
  - done pulse in cycle 65;
  - busy low after that.
- Random out_ready backpressure (about 50%) -> same 32 beats, no drops or duplicates; out_data and out_index stable while out_valid=1 and out_ready=0.
- FIRST_REG=5, LAST_REG=5, r5=32'hDEADBEEF -> exactly one beat {5, DEADBEEF}, done 3 cycles after start.
- abort in the SEND state of beat 10 with out_ready=0 -> out_valid low next cycle, no done, busy low; a new start then replays from index 0.
- Reset asserted mid-dump (beat 7) -> all outputs 0 after the edge; start pulses during the dump and on the DONE cycle are ignored, producing no second dump.
